// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM states, geometry constants and the
// GF(2^8) helpers that the S-box is built from.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int NCOL   = 4;
    localparam int BYTE_W = 8;
    localparam int COL_W  = NCOL * BYTE_W;

    // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the inverse for non-zero a and maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x4, x8, x16, x32, x64, x128, r;
        x2   = gf_mul(a, a);
        x4   = gf_mul(x2, x2);
        x8   = gf_mul(x4, x4);
        x16  = gf_mul(x8, x8);
        x32  = gf_mul(x16, x16);
        x64  = gf_mul(x32, x32);
        x128 = gf_mul(x64, x64);
        r    = gf_mul(x2, x4);
        r    = gf_mul(r, x8);
        r    = gf_mul(r, x16);
        r    = gf_mul(r, x32);
        r    = gf_mul(r, x64);
        r    = gf_mul(r, x128);
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b
             ^ {b[6:0], b[7]}
             ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]}
             ^ 8'h63;
    endfunction

endpackage

// File: rtl/sbox.sv
// Forward AES S-box, purely combinational.
// Ports: x = input byte, y = substituted byte.
module sbox
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] x,
    output logic [BYTE_W-1:0] y
);

    assign y = affine(gf_inv(x));

endmodule

// File: rtl/subbytes_iter.sv
// Iterative SubBytes: one 32-bit column per cycle, 4-cycle latency.
// Ports: clk, reset (async high), in_valid/in_ready/in_state upstream,
// out_valid/out_ready/out_state downstream (out_state is registered).
module subbytes_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    state_t           state;
    state_t           nxt;
    logic [1:0]       col;
    logic [127:0]     work;
    logic [COL_W-1:0] col_in;
    logic [COL_W-1:0] col_out;
    logic [6:0]       base;
    logic             accept;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign out_state = work;
    assign accept    = in_valid && in_ready;

    // Column 0 sits in the top word, so the LSB offset is (3-col)*32.
    assign base   = {~col, 5'b00000};
    assign col_in = work[base +: COL_W];

    for (genvar r = 0; r < NCOL; r++) begin : g_row
        sbox u_sbox (
            .x (col_in[COL_W-1-BYTE_W*r -: BYTE_W]),
            .y (col_out[COL_W-1-BYTE_W*r -: BYTE_W])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (in_valid)     nxt = BUSY;
            BUSY:    if (col == 2'd3)  nxt = DONE;
            DONE:    if (out_ready)    nxt = IDLE;
            default:                   nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col  <= 2'd0;
            work <= 128'h0;
        end else if (accept) begin
            col  <= 2'd0;
            work <= in_state;
        end else if (state == BUSY) begin
            work[base +: COL_W] <= col_out;
            col                 <= col + 2'd1;
        end
    end

endmodule
